// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between IF reads and MEM reads/writes.
// MEM has priority; a grant-streak limit guarantees IF still makes progress.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_busy_o,
    output logic                if_done_o,
    output logic [DATA_W-1:0]   if_data_o,

    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_mask_i,
    output logic                mem_busy_o,
    output logic                mem_done_o,
    output logic [DATA_W-1:0]   mem_data_o,

    output logic                ext_req_o,
    output logic                ext_we_o,
    output logic [ADDR_W-1:0]   ext_addr_o,
    output logic [DATA_W-1:0]   ext_wdata_o,
    output logic [DATA_W/8-1:0] ext_mask_o,
    input  logic                ext_ack_i,
    input  logic [DATA_W-1:0]   ext_rdata_i
);

    localparam int STREAK_W = $clog2(MEM_STREAK_MAX + 1);

    // state     | meaning
    // IDLE      | port free; arbitrate on the next edge
    // SERVE_IF  | port carries an IF read, waiting for ext_ack_i
    // SERVE_MEM | port carries a MEM read or write, waiting for ext_ack_i
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SERVE_IF  = 2'd1;
    localparam logic [1:0] SERVE_MEM = 2'd2;

    logic [1:0]          state;
    logic [STREAK_W-1:0] streak;
    logic                streak_full;
    logic                grant_mem;
    logic                grant_if;

    assign streak_full = (streak == STREAK_W'(MEM_STREAK_MAX));

    // MEM wins ties unless it has already held the port MEM_STREAK_MAX times while IF waited.
    assign grant_mem = (state == IDLE) && mem_req_i && !(if_req_i && streak_full);
    assign grant_if  = (state == IDLE) && !grant_mem && if_req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        state <= SERVE_MEM;
                        if (!if_req_i) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (grant_if) begin
                        state  <= SERVE_IF;
                        streak <= '0;
                    end
                end
                SERVE_IF, SERVE_MEM: begin
                    if (ext_ack_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream request fields are captured at the grant and held until the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_req_o   <= 1'b0;
            ext_we_o    <= 1'b0;
            ext_addr_o  <= '0;
            ext_wdata_o <= '0;
            ext_mask_o  <= '0;
        end else if (grant_mem) begin
            ext_req_o   <= 1'b1;
            ext_we_o    <= mem_we_i;
            ext_addr_o  <= mem_addr_i;
            ext_wdata_o <= mem_wdata_i;
            ext_mask_o  <= mem_mask_i;
        end else if (grant_if) begin
            ext_req_o   <= 1'b1;
            ext_we_o    <= 1'b0;
            ext_addr_o  <= if_addr_i;
            ext_wdata_o <= '0;
            ext_mask_o  <= '1;
        end else if ((state != IDLE) && ext_ack_i) begin
            ext_req_o   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            if_data_o  <= '0;
            mem_data_o <= '0;
        end else begin
            if_done_o  <= (state == SERVE_IF)  && ext_ack_i;
            mem_done_o <= (state == SERVE_MEM) && ext_ack_i;
            if ((state == SERVE_IF) && ext_ack_i) begin
                if_data_o <= ext_rdata_i;
            end
            if ((state == SERVE_MEM) && ext_ack_i && !ext_we_o) begin
                mem_data_o <= ext_rdata_i;
            end
        end
    end

    // Gated by rst so the busy flags read 0 while reset is held.
    assign if_busy_o  = if_req_i  & ~if_done_o  & ~rst;
    assign mem_busy_o = mem_req_i & ~mem_done_o & ~rst;

endmodule
